// File: rtl/rv32_pkg.sv
// Shared rv32 pipeline constants: writeback selectors, load funct3 codes and
// the WB stage state type.
package rv32_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: picks the byte/halfword addressed by the low
// address bits out of the raw memory word, extends it, and flags misalignment.
module load_align
    import rv32_pkg::*;
(
    input  logic [XLEN_DEFAULT-1:0] i_word,
    input  logic [2:0]              i_funct3,
    input  logic [1:0]              i_offset,
    output logic [XLEN_DEFAULT-1:0] o_data,
    output logic                    o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte       = 8'h00;
        w_half       = 16'h0000;
        o_data       = '0;
        o_misaligned = 1'b0;

        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

        // Unlisted funct3 encodings fall through to word semantics.
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_offset[0];
            end
            F3_LHU: begin
                o_data       = {16'h0000, w_half};
                o_misaligned = i_offset[0];
            end
            default: begin
                o_data       = i_word;
                o_misaligned = (i_offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: holds loads until memory data
// arrives, drives the register file write port, forwarding tap and instret.
module wb_stage
    import rv32_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_reg_wen,
    input  logic [4:0]           mem_rd,
    input  logic [1:0]           mem_wb_sel,
    input  logic [2:0]           mem_funct3,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_pc_plus4,
    input  logic [XLEN-1:0]      dmem_rdata,
    input  logic                 dmem_rvalid,
    output logic                 wb_busy,
    output logic                 regWEn,
    output logic [4:0]           addrD,
    output logic [XLEN-1:0]      dataD,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 load_misaligned,
    output logic [INSTRET_W-1:0] instret
);

    wb_state_e            r_state;
    logic                 r_valid;
    logic                 r_regWen;
    logic [4:0]           r_rd;
    logic [1:0]           r_wbSel;
    logic [2:0]           r_funct3;
    logic [XLEN-1:0]      r_alu;
    logic [XLEN-1:0]      r_pc4;
    logic [INSTRET_W-1:0] r_instret;

    logic                 w_isLoad;
    logic                 w_busy;
    logic                 w_retire;
    logic                 w_alignMis;
    logic                 w_misaligned;
    logic                 w_wen;
    logic [XLEN-1:0]      w_loadData;
    logic [XLEN-1:0]      w_selData;

    load_align u_align (
        .i_word       (dmem_rdata),
        .i_funct3     (r_funct3),
        .i_offset     (r_alu[1:0]),
        .o_data       (w_loadData),
        .o_misaligned (w_alignMis)
    );

    // A held entry retires as soon as it is not stalled on load data.
    always_comb begin
        w_isLoad     = (r_wbSel == WB_LOAD);
        w_busy       = ((r_state == WB_WAIT) && !dmem_rvalid) ||
                       ((r_state == WB_IDLE) && r_valid && w_isLoad && !dmem_rvalid);
        w_retire     = r_valid && !w_busy;
        w_misaligned = w_retire && w_isLoad && w_alignMis;
        w_wen        = w_retire && r_regWen && (r_rd != REG_X0) && !w_misaligned;

        case (r_wbSel)
            WB_LOAD: w_selData = w_loadData;
            WB_PC4:  w_selData = r_pc4;
            default: w_selData = r_alu;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= WB_IDLE;
            r_valid   <= 1'b0;
            r_regWen  <= 1'b0;
            r_rd      <= '0;
            r_wbSel   <= WB_ALU;
            r_funct3  <= '0;
            r_alu     <= '0;
            r_pc4     <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_busy ? WB_WAIT : WB_IDLE;
            if (!w_busy) begin
                r_valid  <= mem_valid;
                r_regWen <= mem_reg_wen;
                r_rd     <= mem_rd;
                r_wbSel  <= mem_wb_sel;
                r_funct3 <= mem_funct3;
                r_alu    <= mem_alu_result;
                r_pc4    <= mem_pc_plus4;
            end
            if (w_retire && !w_misaligned)
                r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    assign wb_busy         = w_busy;
    assign regWEn          = w_wen;
    assign addrD           = w_wen ? r_rd : 5'd0;
    assign dataD           = w_wen ? w_selData : '0;
    assign fwd_valid       = w_wen;
    assign fwd_rd          = w_wen ? r_rd : 5'd0;
    assign fwd_data        = w_wen ? w_selData : '0;
    assign load_misaligned = w_misaligned;
    assign instret         = r_instret;

endmodule
